gus_irq_ctrl: RTL and testbench
===============================

# gus_irq_ctrl

Memory-mapped interrupt controller that sits on the GUS16 core bus as a responder and drives the core's `irq`/`ivector` inputs. It latches rising edges from eight peripheral interrupt sources and masks them with a software enable register. The highest-priority enabled pending source is presented to the core as a registered request plus a 3-bit vector. Software acknowledges a source with write-1-to-clear, and raises software interrupts with write-1-to-set.

## Interface
Parameters:
- `BASE`, 16'hFFF0 — register window base; bits [1:0] ignored, window is 4 words.

Ports:
- `clk` in 1 — clock; all state updates on rising edge.
- `reset` in 1 — synchronous reset, active-high.
- `ca` in 16 — core address.
- `cdo` in 16 — core write data.
- `we` in 1 — core write enable, one cycle per store.
- `rdata` out 16 — read data, combinational from `ca` and state.
- `sel` out 1 — combinational; high when `ca[15:2]==BASE[15:2]`. The SoC read mux uses it.
- `src` in 8 — interrupt sources, rising-edge sensitive.
- `irq` out 1 — registered interrupt request to the core.
- `ivector` out 3 — registered vector, index of the winning source.

## Operation
Registers, word offset `ca[1:0]`:
- 0 PEND:
  - read returns {8'h0, pend[7:0]};
  - write clears every `pend` bit whose `cdo` bit is 1 (W1C).
- 1 EN:
  - read/write {8'h0, en[7:0]};
  - `cdo[15:8]` ignored.
- 2 STAT, read-only:
  - {12'h0, irq, ivector};
  - writes ignored.
- 3 SWSET:
  - write sets every `pend` bit whose `cdo` bit is 1;
  - reads return 16'h0.

Register write: occurs at the clock edge when `we & sel`.

Edge detection:
- `src_d` <= `src` every cycle.
- `edge = src & ~src_d`.
- `pend` <= (`pend` & ~w1c) | `edge` | swset, evaluated per bit.
- `pend` sets even when the matching `en` bit is 0. Enabling later raises the request.

Arbitration:
- `act = pend & en`.
- `irq` <= |act.
- `ivector` <= index of the lowest set bit of `act`; bit 0 has highest priority.
- When `act` is 0, `ivector` <= 3'd0.

Core handshake:
- The core reloads its vector on `reti` when `irq` is still high, so chained interrupts need no extra handshake.
- Handlers must W1C their PEND bit before `reti`. `irq` then falls, or moves to the next source, in time for the core to sample it.

Boundary conditions:
- Edge and W1C on the same bit in the same cycle: set wins, so no event is lost.
- SWSET and W1C on the same bit in the same cycle: set wins.
- Source held high: only one pend set. A new event requires a low cycle.
- All eight pending and enabled: `ivector`=0. Clearing bit 0 gives `ivector`=1 two edges later.
- Reset: `pend`=0, `en`=0, `src_d`=8'hFF, `irq`=0, `ivector`=0.
  - Sources high at reset release are not counted as edges.
  - Reset mid-request drops `irq` at the same edge.
- Reset wins over any simultaneous write.

## Timing
- `src` rises before edge k: `pend` set after edge k; `irq`/`ivector` valid after edge k+1. Latency is 2 cycles.
- EN/PEND/SWSET write at edge k: `irq`/`ivector` reflect it after edge k+1.
- `rdata` and `sel` are zero-latency combinational, valid in the same cycle as `ca`, matching the core's load timing.
- A read of PEND in the write cycle returns the pre-write value.
- `irq` and `ivector` change only on clock edges and never glitch.

## Configuration
- `GUS_IRQ_SYNC_EN`:
  - Defined: `src` passes through a 2-flop synchronizer before edge detection. Latency grows to 4 cycles. Synchronizer flops reset to 8'hFF. Use when sources come from asynchronous pins.
  - Undefined: `src` feeds edge detection directly. Sources are then required to be synchronous to `clk`.

## Test plan
- Reset, then read all offsets: PEND=0, EN=0, STAT=0, SWSET read=0; `irq`=0.
- EN=8'h08, pulse `src[3]` for 1 cycle: `pend`=8'h08 after 1 edge; `irq`=1 and `ivector`=3 after 2 edges. W1C 8'h08: `irq`=0 2 edges later.
- EN=8'hFF, SWSET 8'hA4: `ivector`=2. Then W1C 8'h04: `ivector`=5. Then W1C 8'h20: `ivector`=7. `irq` stays 1 throughout, falls after W1C 8'h80.
- EN=0, pulse `src[1]`: `pend[1]`=1 and `irq`=0. Then write EN=8'h02: `irq`=1, `ivector`=1 two edges after the write.
- W1C 8'h10 in the same cycle as a `src[4]` rising edge: `pend[4]` remains 1. Holding `src[4]` high afterwards and clearing it again: no re-set.
- Assert `reset` while `irq`=1 with 8'hFF pending: next edge gives `pend`=0, `en`=0, `irq`=0, `ivector`=0. Sources held high give no request after release.

Source files
------------

// File: rtl/gus_irq_ctrl.sv
// rtl/gus_irq_ctrl.sv - eight-source edge-latched interrupt controller on the GUS16 core bus
// Define GUS_IRQ_SYNC_EN to pass src through a 2-flop synchronizer before edge detection.
module gus_irq_ctrl #(
    parameter logic [15:0] BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ca,
    input  logic [15:0] cdo,
    input  logic        we,
    output logic [15:0] rdata,
    output logic        sel,
    input  logic [7:0]  src,
    output logic        irq,
    output logic [2:0]  ivector
);

    logic [7:0] src_s;
    logic [7:0] src_d_q;
    logic [7:0] pend_q, pend_d;
    logic [7:0] en_q, en_d;
    logic       irq_q, irq_d;
    logic [2:0] ivector_q, ivector_d;
    logic [7:0] edge_det;
    logic [7:0] w1c;
    logic [7:0] swset;
    logic [7:0] act;
    logic       wr;

`ifdef GUS_IRQ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    // Reset high so sources already asserted at release are not seen as edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src;
`endif

    assign sel      = (ca[15:2] == BASE[15:2]);
    assign wr       = we & sel;
    assign w1c      = (wr && ca[1:0] == 2'd0) ? cdo[7:0] : 8'h00;
    assign swset    = (wr && ca[1:0] == 2'd3) ? cdo[7:0] : 8'h00;
    assign edge_det = src_s & ~src_d_q;

    // Sets are ORed after the clear so a same-cycle event is never lost.
    assign pend_d = (pend_q & ~w1c) | edge_det | swset;
    assign en_d   = (wr && ca[1:0] == 2'd1) ? cdo[7:0] : en_q;
    assign act    = pend_d & en_d;
    assign irq_d  = |act;

    always_comb begin
        ivector_d = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) ivector_d = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_d_q   <= 8'hFF;
            pend_q    <= 8'h00;
            en_q      <= 8'h00;
            irq_q     <= 1'b0;
            ivector_q <= 3'd0;
        end else begin
            src_d_q   <= src_s;
            pend_q    <= pend_d;
            en_q      <= en_d;
            irq_q     <= |(pend_q & en_q);
            ivector_q <= ivector_d_q_src(pend_q & en_q);
        end
    end

    function automatic logic [2:0] ivector_d_q_src(input logic [7:0] a);
        logic [2:0] v;
        v = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (a[i]) v = 3'(i);
        end
        return v;
    endfunction

    always_comb begin
        rdata = 16'h0000;
        case (ca[1:0])
            2'd0:    rdata = {8'h00, pend_q};
            2'd1:    rdata = {8'h00, en_q};
            2'd2:    rdata = {12'h000, irq_q, ivector_q};
            default: rdata = 16'h0000;
        endcase
    end

    assign irq     = irq_q;
    assign ivector = ivector_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, irq_d, ivector_d, cdo[15:8]};

endmodule

// File: tb/tb_gus_irq_ctrl.sv
// tb/tb_gus_irq_ctrl.sv - directed self-checking bench for gus_irq_ctrl
module tb_gus_irq_ctrl;

    localparam logic [15:0] BASE = 16'hFFF0;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ca;
    logic [15:0] cdo;
    logic        we;
    logic [15:0] rdata;
    logic        sel;
    logic [7:0]  src;
    logic        irq;
    logic [2:0]  ivector;

    int tests_run = 0;
    int tests_failed = 0;

    gus_irq_ctrl #(.BASE(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .ca      (ca),
        .cdo     (cdo),
        .we      (we),
        .rdata   (rdata),
        .sel     (sel),
        .src     (src),
        .irq     (irq),
        .ivector (ivector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [15:0] data);
        ca  = BASE | 16'(off);
        cdo = data;
        we  = 1'b1;
        tick();
        we  = 1'b0;
        ca  = 16'h0000;
        cdo = 16'h0000;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] off, input logic [15:0] exp);
        ca = BASE | 16'(off);
        #1;
        check(tag, rdata, exp);
        ca = 16'h0000;
    endtask

    task automatic irq_check(input string tag, input logic exp_irq, input logic [2:0] exp_vec);
        check({tag, "_irq"}, 16'(irq), 16'(exp_irq));
        check({tag, "_vec"}, 16'(ivector), 16'(exp_vec));
    endtask

    initial begin
        reset = 1'b1;
        ca    = 16'h0000;
        cdo   = 16'h0000;
        we    = 1'b0;
        src   = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state and register window decode
        rd_check("rst_pend", 2'd0, 16'h0000);
        rd_check("rst_en", 2'd1, 16'h0000);
        rd_check("rst_stat", 2'd2, 16'h0000);
        rd_check("rst_swset", 2'd3, 16'h0000);
        irq_check("rst", 1'b0, 3'd0);
        ca = 16'hFFF3; #1;
        check("sel_hit", 16'(sel), 16'h0001);
        ca = 16'hFFEF; #1;
        check("sel_miss", 16'(sel), 16'h0000);
        ca = 16'h0000;

        // Single source pulse with upper data bits ignored on EN
        wr(2'd1, 16'hFF08);
        rd_check("en_08", 2'd1, 16'h0008);
        src = 8'h08;
        tick();
        src = 8'h00;
        rd_check("pend_08", 2'd0, 16'h0008);
        irq_check("src3_e1", 1'b0, 3'd0);
        tick();
        irq_check("src3_e2", 1'b1, 3'd3);
        rd_check("stat_3", 2'd2, 16'h000B);
        wr(2'd0, 16'h0008);
        rd_check("pend_w1c", 2'd0, 16'h0000);
        irq_check("w1c_e1", 1'b1, 3'd3);
        tick();
        irq_check("w1c_e2", 1'b0, 3'd0);

        // Software set and priority walk
        wr(2'd1, 16'h00FF);
        wr(2'd3, 16'h00A4);
        rd_check("swset_rd", 2'd3, 16'h0000);
        tick();
        irq_check("sw_a4", 1'b1, 3'd2);
        wr(2'd0, 16'h0004);
        tick();
        irq_check("sw_clr04", 1'b1, 3'd5);
        wr(2'd0, 16'h0020);
        tick();
        irq_check("sw_clr20", 1'b1, 3'd7);
        wr(2'd0, 16'h0080);
        tick();
        irq_check("sw_clr80", 1'b0, 3'd0);

        // Pending while disabled, raised by a later enable
        wr(2'd1, 16'h0000);
        src = 8'h02;
        tick();
        src = 8'h00;
        tick();
        rd_check("dis_pend", 2'd0, 16'h0002);
        irq_check("dis", 1'b0, 3'd0);
        wr(2'd1, 16'h0002);
        tick();
        irq_check("late_en", 1'b1, 3'd1);
        wr(2'd0, 16'h0002);
        tick();

        // Edge and W1C on the same bit in one cycle: set wins, held source does not re-set
        ca  = BASE;
        cdo = 16'h0010;
        we  = 1'b1;
        src = 8'h10;
        tick();
        we  = 1'b0;
        ca  = 16'h0000;
        rd_check("edge_vs_w1c", 2'd0, 16'h0010);
        wr(2'd0, 16'h0010);
        rd_check("held_clr", 2'd0, 16'h0000);
        tick();
        tick();
        rd_check("held_noset", 2'd0, 16'h0000);
        src = 8'h00;
        tick();

        // All pending: bit 0 wins, then bit 1 after clearing bit 0
        wr(2'd1, 16'h00FF);
        wr(2'd3, 16'h00FF);
        tick();
        irq_check("all_pend", 1'b1, 3'd0);
        wr(2'd0, 16'h0001);
        tick();
        irq_check("all_clr0", 1'b1, 3'd1);

        // Reset mid-request, with a simultaneous write and sources held high
        src   = 8'hFF;
        reset = 1'b1;
        ca    = BASE | 16'd1;
        cdo   = 16'h00FF;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        ca    = 16'h0000;
        irq_check("rst_mid", 1'b0, 3'd0);
        rd_check("rst_mid_pend", 2'd0, 16'h0000);
        rd_check("rst_mid_en", 2'd1, 16'h0000);
        reset = 1'b0;
        tick();
        tick();
        rd_check("rel_pend", 2'd0, 16'h0000);
        wr(2'd1, 16'h00FF);
        tick();
        tick();
        irq_check("rel_held", 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
